// File: rtl/regfile_param.sv
// Register file: DEPTH x DATA_WIDTH, NUM_READ registered read ports, one write port, r0 reads zero; post-reset init clears all and loads SP.
// Latency: reads 1 cycle; init takes DEPTH cycles after leaving reset. Optional same-edge forwarding via REGFILE_BYPASS_EN.
// Backpressure: none; Ready stays low until init is done, and writes presented while Ready is low are dropped.
module regfile_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int SP_INDEX   = 29,
    parameter int SP_INIT    = 252
) (
    input  logic                           Clk,
    input  logic                           Rst_n,
    input  logic                           RegWrite,
    input  logic [ADDR_WIDTH-1:0]          WriteRegister,
    input  logic [DATA_WIDTH-1:0]          WriteData,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ReadRegister,
    output logic [NUM_READ*DATA_WIDTH-1:0] ReadData,
    output logic                           Ready
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  stateNext;
    logic [ADDR_WIDTH-1:0]   initCnt;
    logic [DATA_WIDTH-1:0]   initVal;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   rdAddr [NUM_READ];
    logic [DATA_WIDTH-1:0]   readNext [NUM_READ];
    logic [NUM_READ*DATA_WIDTH-1:0] readDataQ;
    logic                    readyQ;
    logic                    wrEn;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state   <= ST_RST;
            initCnt <= '0;
            readyQ  <= 1'b0;
        end else begin
            state  <= stateNext;
            readyQ <= (stateNext == ST_RUN);
            if (state == ST_INIT) begin
                initCnt <= initCnt + ADDR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_RST:  stateNext = ST_INIT;
            ST_INIT: if (&initCnt) stateNext = ST_RUN;
            ST_RUN:  stateNext = ST_RUN;
            default: stateNext = ST_RST;
        endcase
    end

    assign initVal = (initCnt == ADDR_WIDTH'(SP_INDEX)) ? DATA_WIDTH'(SP_INIT) : '0;
    assign wrEn    = (state == ST_RUN) && RegWrite && (WriteRegister != '0);

    // The array has no reset of its own: the init sequence is its reset, so a
    // reset leaves contents alone until the counter sweeps over them.
    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            if (state == ST_INIT) begin
                mem[initCnt] <= initVal;
            end else if (wrEn) begin
                mem[WriteRegister] <= WriteData;
            end
        end
    end

    for (genvar g = 0; g < NUM_READ; g++) begin : g_rdAddr
        assign rdAddr[g] = ReadRegister[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    always_comb begin
        for (int k = 0; k < NUM_READ; k++) begin
            readNext[k] = '0;
            if ((state == ST_RUN) && (rdAddr[k] != '0)) begin
                readNext[k] = mem[rdAddr[k]];
`ifdef REGFILE_BYPASS_EN
                if (wrEn && (WriteRegister == rdAddr[k])) begin
                    readNext[k] = WriteData;
                end
`endif
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            readDataQ <= '0;
        end else begin
            for (int k = 0; k < NUM_READ; k++) begin
                readDataQ[k*DATA_WIDTH +: DATA_WIDTH] <= readNext[k];
            end
        end
    end

    assign ReadData = readDataQ;
    assign Ready    = readyQ;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param (default parameters, two read ports); expectations go through a scoreboard queue.
module tb_regfile_param;
    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [9:0]  ReadRegister;
    logic [63:0] ReadData;
    logic        Ready;

    int checks   = 0;
    int failures = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        int          port;
        logic [31:0] data;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [32];

    regfile_param dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .RegWrite(RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData(WriteData),
        .ReadRegister(ReadRegister),
        .ReadData(ReadData),
        .Ready(Ready)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_rd(input int port, input logic [31:0] d, input string tag);
        exp_t e;
        e.port = port;
        e.data = d;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Drive one cycle of write/read stimulus, then compare everything queued for that edge.
    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r0, input logic [4:0] r1);
        exp_t e;
        RegWrite      = we;
        WriteRegister = wa;
        WriteData     = wd;
        ReadRegister  = {r1, r0};
        tick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, ReadData[e.port*32 +: 32], e.data);
        end
    endtask

    // Leave reset, take the RST->INIT edge, then count cycles until Ready rises.
    task automatic run_init(input string tag, input bit initWrite);
        int waited;
        Rst_n = 1'b1;
        tick();
        check({tag, "_ready_at_init"}, {31'b0, Ready}, 32'd0);
        waited = 0;
        while (Ready !== 1'b1 && waited < 100) begin
            RegWrite      = initWrite && (waited == 10);
            WriteRegister = 5'd3;
            WriteData     = 32'h0000AAAA;
            ReadRegister  = {5'd29, 5'd3};
            tick();
            waited++;
            if (waited == 20) begin
                check({tag, "_rdata_in_init"}, ReadData[31:0] | ReadData[63:32], 32'd0);
            end
        end
        RegWrite = 1'b0;
        check({tag, "_init_cycles"}, waited, 32'd32);
    endtask

    initial begin
        Rst_n         = 1'b0;
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        ReadRegister  = {5'd29, 5'd5};
        repeat (3) tick();
        check("rst_ready", {31'b0, Ready}, 32'd0);
        check("rst_rdata0", ReadData[31:0], 32'd0);
        check("rst_rdata1", ReadData[63:32], 32'd0);

        run_init("init1", 1'b1);

        expect_rd(0, 32'd252, "sp_init");
        expect_rd(1, 32'd0, "r0_init");
        step(0, 0, 0, 29, 0);
        expect_rd(0, 32'd0, "r8_init");
        expect_rd(1, 32'd0, "r31_init");
        step(0, 0, 0, 8, 31);
        expect_rd(0, 32'd0, "r3_init_write_ignored");
        step(0, 0, 0, 3, 3);

        expect_rd(0, 32'd0, "wr5_cycle_p0");
        expect_rd(1, 32'd0, "wr5_cycle_p1");
        step(1, 5, 32'hDEADBEEF, 0, 0);
        expect_rd(0, 32'hDEADBEEF, "r5_p0");
        expect_rd(1, 32'hDEADBEEF, "r5_p1");
        step(0, 0, 0, 5, 5);

        expect_rd(0, 32'd0, "r0_same_cycle_p0");
        expect_rd(1, 32'd0, "r0_same_cycle_p1");
        step(1, 0, 32'hFFFFFFFF, 0, 0);
        expect_rd(0, 32'd0, "r0_after_p0");
        expect_rd(1, 32'd0, "r0_after_p1");
        step(0, 0, 0, 0, 0);

        expect_rd(0, 32'hDEADBEEF, "byp_other_port");
        expect_rd(1, BYP ? 32'h12345678 : 32'd0, "byp_r7_same_edge");
        step(1, 7, 32'h12345678, 5, 7);
        expect_rd(0, 32'h12345678, "r7_next_p0");
        expect_rd(1, 32'h12345678, "r7_next_p1");
        step(0, 0, 0, 7, 7);

        expect_rd(0, BYP ? 32'hCAFEF00D : 32'hDEADBEEF, "byp_r5_p0");
        expect_rd(1, BYP ? 32'hCAFEF00D : 32'hDEADBEEF, "byp_r5_p1");
        step(1, 5, 32'hCAFEF00D, 5, 5);
        expect_rd(0, 32'hCAFEF00D, "r5_new");
        expect_rd(1, 32'h12345678, "r7_kept");
        step(0, 0, 0, 5, 7);

        step(1, 12, 32'h55, 0, 0);
        expect_rd(0, 32'h55, "r12_written");
        step(0, 0, 0, 12, 12);

        // Mid-run reset: Ready must fall on the reset edge and the sweep must clear r12.
        Rst_n        = 1'b0;
        ReadRegister = {5'd12, 5'd5};
        tick();
        check("midrst_ready", {31'b0, Ready}, 32'd0);
        check("midrst_rdata", ReadData[31:0] | ReadData[63:32], 32'd0);
        run_init("init2", 1'b0);
        expect_rd(0, 32'd0, "r12_cleared");
        expect_rd(1, 32'd252, "sp_reinit");
        step(0, 0, 0, 12, 29);

        for (int i = 0; i < 32; i++) model[i] = (i == 29) ? 32'd252 : 32'd0;
        for (int i = 1; i < 32; i += 3) begin
            logic [31:0] d;
            d = $urandom;
            model[i] = d;
            step(1, 5'(i), d, 0, 0);
        end
        for (int i = 0; i < 32; i += 2) begin
            expect_rd(0, model[i], "rand_p0");
            expect_rd(1, model[31 - i], "rand_p1");
            step(0, 0, 0, 5'(i), 5'(31 - i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
